// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with 2-FF input synchroniser, mid-bit sampling and a byte FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       CLK100MHZ,
  input  logic       ck_rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       parity_err
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_HALF = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic        baud_zero;
  logic        push, push_ok;

  // rxd_prev is one cycle behind the synchronised value, for falling-edge detection
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign baud_zero = (baud_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err_r;
  assign push_ok    = ~par_bad;
  assign parity_err = parity_err_r;
`else
  assign push_ok    = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign push = (state == S_STOP) && baud_zero && rxd_sync && push_ok;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            state    <= S_START;
            baud_cnt <= BAUD_HALF;
          end
        end
        S_START: begin
          if (baud_zero) begin
            if (rxd_sync) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              baud_cnt <= BAUD_FULL;
              bit_cnt  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            shreg    <= {rxd_sync, shreg[7:1]};
            baud_cnt <= BAUD_FULL;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_zero) begin
            par_bad      <= ^{shreg, rxd_sync};
            parity_err_r <= ^{shreg, rxd_sync};
            baud_cnt     <= BAUD_FULL;
            state        <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_zero) begin
            if (!rxd_sync) begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (rxd_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & rx_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | pop);

  always_ff @(posedge CLK100MHZ) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rx_valid = ~empty;
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule
